// File: rtl/juego_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : juego_pkg
//  Description : Shared types for the quadrant memory game. The state codes
//                are also decoded by the quadrant selector mux, so their
//                values are fixed.
//  Contents    : estado_t    - 4-bit game state code (IDLE..FALLO)
//                cuadrante_t - 2-bit quadrant index
//                siguiente_cuadrante() - cursor step, wraps 3 -> 0
//                suma_saturada()       - 8-bit increment saturating at 255
//  Revision    : 1.0 - initial release
// ============================================================================
package juego_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'b0000,
    MOSTRAR   = 4'b0001,
    OCULTAR   = 4'b0010,
    SELECCION = 4'b0011,
    VERIFICAR = 4'b0100,
    ACIERTO   = 4'b0101,
    FALLO     = 4'b0110
  } estado_t;

  typedef logic [1:0] cuadrante_t;

  localparam cuadrante_t c_cuadrante_0 = 2'b00;
  localparam logic [7:0] c_score_max   = 8'hFF;

  // Cursor advance; the 2-bit add wraps 11 -> 00 on its own.
  function automatic cuadrante_t siguiente_cuadrante(input cuadrante_t q);
    return q + 2'd1;
  endfunction

  function automatic logic [7:0] suma_saturada(input logic [7:0] s);
    return (s == c_score_max) ? s : s + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/detector_flanco.sv
`default_nettype none
// ============================================================================
//  Module      : detector_flanco
//  Description : Registered rising-edge detector for a debounced button
//                level. A level held high yields a single one-cycle pulse.
//  Ports       : clk   - system clock
//                rst_n - asynchronous reset, active-low
//                din   - debounced button level
//                pulse - one-cycle pulse, registered, one cycle after the
//                        rising edge of din is sampled
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic r_din_q;
  logic r_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_q <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_din_q <= din;
      r_pulse <= din & ~r_din_q;
    end
  end

  assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/fsm_cuadrante.sv
`default_nettype none
// ============================================================================
//  Module      : fsm_cuadrante
//  Description : Game-control state machine for the quadrant memory game.
//                Latches the random target, times the show / blank / result
//                phases in VGA frames, moves the player cursor and keeps the
//                score. Feeds the quadrant selector mux.
//  Ports       : clk              - system clock (pixel clock domain)
//                rst_n            - asynchronous reset, active-low
//                frame_tick       - one-cycle pulse per VGA frame
//                btn_next         - debounced level, move-cursor button
//                btn_ok           - debounced level, start/confirm button
//                cuadrante_random - current random quadrant
//                state            - game state code (mux select)
//                cuadrante_fsm    - player cursor quadrant
//                rand_freeze      - high while the target is shown
//                score            - correct rounds in the current game
//  Revision    : 1.0 - initial release
// ============================================================================
module fsm_cuadrante
  import juego_pkg::*;
#(
  parameter int unsigned SHOW_FRAMES    = 60,
  parameter int unsigned BLANK_FRAMES   = 15,
  parameter int unsigned RESULT_FRAMES  = 60,
  parameter int unsigned TIMEOUT_FRAMES = 300,
  parameter int          CNT_W          = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_next,
  input  logic       btn_ok,
  input  logic [1:0] cuadrante_random,
  output logic [3:0] state,
  output logic [1:0] cuadrante_fsm,
  output logic       rand_freeze,
  output logic [7:0] score
);

  // A timed phase ends on the tick that would bring the count to N, i.e.
  // while the count still reads N-1.
  localparam logic [CNT_W-1:0] c_show_last    = CNT_W'(SHOW_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_blank_last   = CNT_W'(BLANK_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_result_last  = CNT_W'(RESULT_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Button edge detection
  // --------------------------------------------------------------------------
  logic w_next_press;
  logic w_ok_press;

  detector_flanco u_det_next (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_next),
    .pulse (w_next_press)
  );

  detector_flanco u_det_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_ok),
    .pulse (w_ok_press)
  );

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  estado_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  cuadrante_t       r_target;
  cuadrante_t       r_cursor;
  logic [7:0]       r_score;
  logic             r_rand_freeze;

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  estado_t    w_state_nxt;
  cuadrante_t w_target_nxt;
  cuadrante_t w_cursor_nxt;
  logic [7:0] w_score_nxt;

  logic w_fin_show;
  logic w_fin_blank;
  logic w_fin_result;
  logic w_fin_timeout;

  assign w_fin_show    = frame_tick && (r_cnt == c_show_last);
  assign w_fin_blank   = frame_tick && (r_cnt == c_blank_last);
  assign w_fin_result  = frame_tick && (r_cnt == c_result_last);
  assign w_fin_timeout = frame_tick && (r_cnt == c_timeout_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_cursor_nxt = r_cursor;
    w_score_nxt  = r_score;

    case (r_state)
      IDLE: begin
        w_cursor_nxt = c_cuadrante_0;
        if (w_ok_press) begin
          w_score_nxt  = 8'd0;
          w_target_nxt = cuadrante_random;
          w_state_nxt  = MOSTRAR;
        end
      end

      MOSTRAR: begin
        if (w_fin_show) begin
          w_state_nxt = OCULTAR;
        end
      end

      OCULTAR: begin
        if (w_fin_blank) begin
          w_cursor_nxt = c_cuadrante_0;
          w_state_nxt  = SELECCION;
        end
      end

      SELECCION: begin
        // Confirm has priority over both the cursor move and the timeout.
        if (w_ok_press) begin
          w_state_nxt = VERIFICAR;
        end else begin
          if (w_next_press) begin
            w_cursor_nxt = siguiente_cuadrante(r_cursor);
          end
          if (w_fin_timeout) begin
            w_state_nxt = FALLO;
          end
        end
      end

      VERIFICAR: begin
        if (r_cursor == r_target) begin
          w_score_nxt = suma_saturada(r_score);
          w_state_nxt = ACIERTO;
        end else begin
          w_state_nxt = FALLO;
        end
      end

      ACIERTO: begin
        // Next round: a fresh target is taken on the way back to MOSTRAR.
        if (w_fin_result) begin
          w_target_nxt = cuadrante_random;
          w_state_nxt  = MOSTRAR;
        end
      end

      FALLO: begin
        if (w_fin_result) begin
          w_cursor_nxt = c_cuadrante_0;
          w_state_nxt  = IDLE;
        end
      end

      default: begin
        // Unused codes 0111-1111 recover to IDLE.
        w_cursor_nxt = c_cuadrante_0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_target      <= c_cuadrante_0;
      r_cursor      <= c_cuadrante_0;
      r_score       <= 8'd0;
      r_rand_freeze <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_target      <= w_target_nxt;
      r_cursor      <= w_cursor_nxt;
      r_score       <= w_score_nxt;
      r_rand_freeze <= (w_state_nxt == MOSTRAR);

      // Frame count restarts on every state change.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (frame_tick) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign state         = r_state;
  assign cuadrante_fsm = r_cursor;
  assign rand_freeze   = r_rand_freeze;
  assign score         = r_score;

endmodule
`default_nettype wire
